md_scheduler: RTL and testbench
===============================

Name: md_scheduler

Overview:
- Multi-cycle multiply/divide sequencer and HI/LO register owner for the 5-stage pipeline.
- Accepts a mult/div/mthi/mtlo operation from the E stage and holds busy for a fixed latency.
- Commits results to HI/LO and drives a D-stage stall request into the hazard logic, so that any later HI/LO-related instruction waits until the unit is free.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (must be >= 1)
DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1)

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  E-stage instruction is a valid MD operation this cycle
md_op  in  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; 110/111 reserved
rs_val  in  32  forwarded rs operand from E stage
rt_val  in  32  forwarded rt operand from E stage
d_uses_md  in  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
hi  out  32  HI register, read by mfhi in E
lo  out  32  LO register, read by mflo in E
busy  out  1  multi-cycle operation in progress
stall_md  out  1  stall request to hazard unit
md_err  out  1  sticky: start accepted while busy, or reserved md_op

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, cnt=0, hi=lo=0, pending=0, md_err=0.
  - Outputs follow immediately: busy=0, stall_md=0.
  - A reset asserted mid-operation aborts it; no partial HI/LO write occurs.
- States: IDLE, RUN. busy = (state==RUN).
- IDLE, start=1, md_op in {mult, multu, div, divu}:
  - At the clock edge, latch the 64-bit result into pending.
  - Load cnt with MULT_CYCLES or DIV_CYCLES; go to RUN.
- IDLE, start=1, md_op=mthi or mtlo:
  - Write rs_val into hi or lo at the edge. Stay IDLE; busy is never raised.
- RUN: cnt decrements every edge. At the edge where cnt==1:
  - {hi,lo} <= pending; state goes to IDLE.
  - busy is therefore high for exactly N cycles after the start cycle.
  - New HI/LO values are visible in the first cycle with busy=0.
- Latency example: start sampled at edge k. busy is high in cycles k+1..k+N. hi/lo update at edge k+N.
- Arithmetic:
  - mult: signed 64-bit product. multu: unsigned 64-bit product. hi=[63:32], lo=[31:0].
  - div/divu: lo=quotient, hi=remainder.
  - Signed quotient truncates toward zero; remainder takes the sign of the dividend.
  - Signed overflow 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - Divide by zero: full DIV_CYCLES busy period runs, then hi/lo are left unchanged (pending is not committed).
- stall_md = d_uses_md & (busy | (start & md_op in mult/multu/div/divu)).
  - This covers the back-to-back case where the E-stage start and the D-stage user meet in the same cycle.
- start while RUN:
  - Ignored; the current operation continues and md_err is set.
  - The hazard unit is required to prevent this case.
- Reserved md_op with start=1: no state change; md_err is set.
- md_err clears only on reset.
- mfhi/mflo read hi/lo combinationally; the scheduler has no read handshake.

Decomposition:
- Shared package md_pkg holds:
  - MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO encodings.
  - The md_state_t enum (IDLE, RUN).
  - Default latency constants.
  - The decoder in control uses the same encodings.
- One sub-module, md_alu: purely combinational.
  - Inputs: md_op, rs_val, rt_val.
  - Outputs: 64-bit result, div_by_zero flag.
  - Signed/unsigned and overflow rules live here.
- md_scheduler holds only the FSM, counter, pending, HI/LO and stall logic.

Test Plan:
- Reset release, then mult rs=0xFFFFFFFE(-2), rt=3 -> busy high exactly 5 cycles; afterwards hi=0xFFFFFFFF, lo=0xFFFFFFFA; hi/lo unchanged during busy.
- multu rs=0xFFFFFFFF, rt=0xFFFFFFFF -> after 5 busy cycles hi=0xFFFFFFFE, lo=0x00000001.
- div rs=0xFFFFFFF9(-7), rt=2 -> 10 busy cycles, then lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1). Repeat with divu rs=7, rt=0 -> 10 busy cycles, hi/lo keep previous values.
- Stall coverage:
  - mult in E with d_uses_md=1 in the same cycle -> stall_md=1 that cycle and through all busy cycles, then drops with busy.
  - d_uses_md=0 while busy -> stall_md=0.
- mthi rs=0x12345678, then mtlo rs=0x9ABCDEF0 on consecutive cycles -> hi/lo update one edge each, busy never asserts.
- div started, reset pulsed low at busy cycle 4 -> immediate busy=0, hi=lo=0, no later commit. start during RUN -> md_err=1 and the first result still commits.

Source files
------------

// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared encodings, state type and latency defaults for the MD unit
//
// Purpose: one place for the md_op encodings so the control decoder, the
// scheduler and md_alu all agree, plus the scheduler state type and the
// default busy latencies.
// Ports: none (package).
package md_pkg;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_t;

  // True for the four ops that occupy the unit for a multi-cycle busy period.
  function automatic logic is_multicycle(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_scheduler_if.sv
// rtl/md_scheduler_if.sv - E/D-stage request and HI/LO result bundle for md_scheduler
//
// Purpose: groups the pipeline-facing signals of the multiply/divide unit.
// Ports (signals):
//   start, md_op[2:0], rs_val[31:0], rt_val[31:0], d_uses_md : pipeline -> unit
//   hi[31:0], lo[31:0], busy, stall_md, md_err              : unit -> pipeline
// Modports: master = pipeline/hazard side, slave = md_scheduler.
interface md_scheduler_if;

  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        d_uses_md;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall_md;
  logic        md_err;

  modport master (
    output start, md_op, rs_val, rt_val, d_uses_md,
    input  hi, lo, busy, stall_md, md_err
  );

  modport slave (
    input  start, md_op, rs_val, rt_val, d_uses_md,
    output hi, lo, busy, stall_md, md_err
  );

endinterface

// File: rtl/md_alu.sv
// rtl/md_alu.sv - combinational multiply/divide datapath
//
// Purpose: produces the 64-bit {hi,lo} value for mult/multu/div/divu.
// Ports:
//   md_op[2:0]     in  operation encoding (md_pkg)
//   rs_val[31:0]   in  first operand / dividend
//   rt_val[31:0]   in  second operand / divisor
//   result[63:0]   out {hi,lo}; for divides hi=remainder, lo=quotient
//   div_by_zero    out divide op with rt_val==0 (result is then meaningless)
module md_alu
  import md_pkg::*;
(
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic [31:0] quot;
  logic [31:0] rem;
  logic        rt_zero;
  logic        sdiv_ovf;

  assign rt_zero  = (rt_val == 32'h0);
  // The one signed quotient that does not fit in 32 bits; pinned explicitly
  // rather than relying on how the simulator/synthesizer wraps it.
  assign sdiv_ovf = (rs_val == 32'h8000_0000) && (rt_val == 32'hFFFF_FFFF);

  always_comb begin
    result      = 64'h0;
    div_by_zero = 1'b0;
    quot        = 32'h0;
    rem         = 32'h0;
    case (md_op)
      MD_MULT: begin
        result = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
      end
      MD_MULTU: begin
        result = {32'h0, rs_val} * {32'h0, rt_val};
      end
      MD_DIV: begin
        if (rt_zero) begin
          div_by_zero = 1'b1;
        end else if (sdiv_ovf) begin
          quot = 32'h8000_0000;
          rem  = 32'h0;
        end else begin
          // SV signed / and % truncate toward zero, remainder follows dividend.
          quot = $signed(rs_val) / $signed(rt_val);
          rem  = $signed(rs_val) % $signed(rt_val);
        end
        result = {rem, quot};
      end
      MD_DIVU: begin
        if (rt_zero) begin
          div_by_zero = 1'b1;
        end else begin
          quot = rs_val / rt_val;
          rem  = rs_val % rt_val;
        end
        result = {rem, quot};
      end
      default: begin
        result = 64'h0;
      end
    endcase
  end

endmodule

// File: rtl/md_scheduler.sv
// rtl/md_scheduler.sv - multi-cycle mult/div sequencer, HI/LO owner and D-stage stall source
//
// Purpose: accepts MD ops from E, holds busy for a fixed latency, commits the
// result into HI/LO and requests a D-stage stall for later HI/LO users.
// Ports:
//   clk     in  pipeline clock, rising edge
//   reset   in  asynchronous active-low reset
//   md      slave modport of md_scheduler_if (request, HI/LO, busy, stall, error)
// Parameters: MULT_CYCLES / DIV_CYCLES busy cycles (each >= 1).
module md_scheduler
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input logic          clk,
  input logic          reset,
  md_scheduler_if.slave md
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_t   state;
  logic [CNT_W-1:0] cnt;
  logic [63:0] pending;
  logic        pending_ok;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        err_q;

  logic [63:0] alu_result;
  logic        alu_dz;
  logic        is_div;

  md_alu u_alu (
    .md_op       (md.md_op),
    .rs_val      (md.rs_val),
    .rt_val      (md.rt_val),
    .result      (alu_result),
    .div_by_zero (alu_dz)
  );

  assign is_div = (md.md_op == MD_DIV) || (md.md_op == MD_DIVU);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      pending    <= 64'h0;
      pending_ok <= 1'b0;
      hi_q       <= 32'h0;
      lo_q       <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (md.start) begin
            if (is_multicycle(md.md_op)) begin
              pending    <= alu_result;
              // Divide by zero still runs the full busy period, but the
              // result is dropped so HI/LO keep their previous values.
              pending_ok <= !alu_dz;
              cnt        <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
              state      <= RUN;
            end else if (md.md_op == MD_MTHI) begin
              hi_q <= md.rs_val;
            end else if (md.md_op == MD_MTLO) begin
              lo_q <= md.rs_val;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        RUN: begin
          // The hazard unit should never let this happen; flag it and keep going.
          if (md.start) begin
            err_q <= 1'b1;
          end
          if (cnt == CNT_W'(1)) begin
            if (pending_ok) begin
              hi_q <= pending[63:32];
              lo_q <= pending[31:0];
            end
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign md.hi     = hi_q;
  assign md.lo     = lo_q;
  assign md.busy   = (state == RUN);
  assign md.md_err = err_q;
  // The start term catches an MD op in E meeting a HI/LO user in D in the
  // same cycle, before busy has had a chance to rise.
  assign md.stall_md = md.d_uses_md &
                       ((state == RUN) | (md.start & is_multicycle(md.md_op)));

endmodule

// File: tb/tb_md_scheduler.sv
// tb/tb_md_scheduler.sv - directed table-driven bench for md_scheduler
module tb_md_scheduler;
  import md_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  md_scheduler_if mdi ();

  md_scheduler #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .md    (mdi)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    int          exp_cyc;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs [8];
  int   vectors    = 0;
  int   miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [2:0] op, input logic [31:0] rs,
                       input logic [31:0] rt);
    mdi.start  = s;
    mdi.md_op  = op;
    mdi.rs_val = rs;
    mdi.rt_val = rt;
  endtask

  task automatic run_op(input int idx, input vec_t v);
    logic [31:0] h0;
    logic [31:0] l0;
    int          n;
    logic        held;
    h0   = mdi.hi;
    l0   = mdi.lo;
    n    = 0;
    held = 1'b1;
    drive(1'b1, v.op, v.rs, v.rt);
    step();
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    while (mdi.busy && n < 40) begin
      if (mdi.hi !== h0 || mdi.lo !== l0) held = 1'b0;
      n++;
      step();
    end
    chk($sformatf("v%0d busy_cycles", idx), 32'(n), 32'(v.exp_cyc));
    chk($sformatf("v%0d hilo_held", idx), {31'h0, held}, 32'h1);
    chk($sformatf("v%0d hi", idx), mdi.hi, v.exp_hi);
    chk($sformatf("v%0d lo", idx), mdi.lo, v.exp_lo);
  endtask

  initial begin
    int n;
    reset         = 1'b0;
    mdi.d_uses_md = 1'b0;
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    #12;
    chk("rst busy", {31'h0, mdi.busy}, 32'h0);
    chk("rst stall", {31'h0, mdi.stall_md}, 32'h0);
    chk("rst hi", mdi.hi, 32'h0);
    chk("rst lo", mdi.lo, 32'h0);
    chk("rst md_err", {31'h0, mdi.md_err}, 32'h0);
    reset = 1'b1;
    step();

    vecs[0] = '{MD_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1] = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{MD_DIVU,  32'h0000_0007, 32'h0000_0000, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[4] = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{MD_DIVU,  32'h0000_0064, 32'h0000_0007, 10, 32'h0000_0002, 32'h0000_000E};
    vecs[6] = '{MD_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[7] = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 5,  32'h4000_0000, 32'h0000_0000};

    for (int i = 0; i < 8; i++) begin
      run_op(i, vecs[i]);
    end

    // Stall: mult in E meets a HI/LO user in D, then D user disappears mid-busy.
    mdi.d_uses_md = 1'b1;
    drive(1'b1, MD_MULT, 32'h3, 32'h4);
    #1;
    chk("stall start_cycle", {31'h0, mdi.stall_md}, 32'h1);
    step();
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    n = 0;
    while (mdi.busy && n < 40) begin
      mdi.d_uses_md = (n != 2);
      #1;
      chk($sformatf("stall busy_c%0d", n), {31'h0, mdi.stall_md}, {31'h0, (n != 2)});
      n++;
      step();
    end
    chk("stall busy_cycles", 32'(n), 32'd5);
    mdi.d_uses_md = 1'b1;
    #1;
    chk("stall after_busy", {31'h0, mdi.stall_md}, 32'h0);
    chk("stall lo", mdi.lo, 32'h0000_000C);
    mdi.d_uses_md = 1'b0;

    // mthi then mtlo on consecutive cycles.
    drive(1'b1, MD_MTHI, 32'h1234_5678, 32'h0);
    step();
    chk("mthi hi", mdi.hi, 32'h1234_5678);
    chk("mthi lo", mdi.lo, 32'h0000_000C);
    chk("mthi busy", {31'h0, mdi.busy}, 32'h0);
    drive(1'b1, MD_MTLO, 32'h9ABC_DEF0, 32'h0);
    step();
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    chk("mtlo lo", mdi.lo, 32'h9ABC_DEF0);
    chk("mtlo hi", mdi.hi, 32'h1234_5678);
    chk("mtlo busy", {31'h0, mdi.busy}, 32'h0);

    // Reset in busy cycle 4 of a divide aborts it with no later commit.
    drive(1'b1, MD_DIV, 32'd100, 32'd7);
    step();
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    repeat (3) step();
    chk("abort busy_c4", {31'h0, mdi.busy}, 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("abort busy", {31'h0, mdi.busy}, 32'h0);
    chk("abort hi", mdi.hi, 32'h0);
    chk("abort lo", mdi.lo, 32'h0);
    #3 reset = 1'b1;
    repeat (12) step();
    chk("abort late_busy", {31'h0, mdi.busy}, 32'h0);
    chk("abort late_hi", mdi.hi, 32'h0);
    chk("abort late_lo", mdi.lo, 32'h0);

    // start while RUN: flagged, ignored, first result still commits.
    chk("err pre", {31'h0, mdi.md_err}, 32'h0);
    drive(1'b1, MD_MULT, 32'd6, 32'd7);
    step();
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    n = 0;
    while (mdi.busy && n < 40) begin
      if (n == 1) drive(1'b1, MD_DIV, 32'd9, 32'd3);
      else drive(1'b0, 3'b000, 32'h0, 32'h0);
      n++;
      step();
    end
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    chk("err busy_cycles", 32'(n), 32'd5);
    chk("err md_err", {31'h0, mdi.md_err}, 32'h1);
    chk("err hi", mdi.hi, 32'h0);
    chk("err lo", mdi.lo, 32'h0000_002A);
    repeat (2) step();
    chk("err no_second", {31'h0, mdi.busy}, 32'h0);

    // Reserved op: no state change, sticky error until reset.
    reset = 1'b0;
    #2 reset = 1'b1;
    step();
    drive(1'b1, 3'b110, 32'h55, 32'h0);
    step();
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    chk("rsv md_err", {31'h0, mdi.md_err}, 32'h1);
    chk("rsv busy", {31'h0, mdi.busy}, 32'h0);
    chk("rsv hi", mdi.hi, 32'h0);
    chk("rsv lo", mdi.lo, 32'h0);
    step();
    chk("rsv sticky", {31'h0, mdi.md_err}, 32'h1);
    reset = 1'b0;
    #1;
    chk("rsv cleared", {31'h0, mdi.md_err}, 32'h0);
    reset = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
